serial_in_parallel_out_sipo_rx: RTL and testbench

//  Receive side of the LSB-first serial link driven by our PISO shift registers.

---
 rtl/sipo_rx_pkg.sv | 21 ++
 rtl/sipo_rx_out_buf.sv | 42 ++++
 rtl/serial_in_parallel_out_sipo_rx.sv | 103 ++++++++++
 tb/tb_serial_in_parallel_out_sipo_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// rtl/sipo_rx_pkg.sv - shared types and frame-length helper for the SIPO receiver
// Optional feature macro: SIPO_RX_PARITY_CHECK_EN (adds one even-parity bit per frame).
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

`ifdef SIPO_RX_PARITY_CHECK_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_bits(input int data_width);
        return data_width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/sipo_rx_out_buf.sv
// rtl/sipo_rx_out_buf.sv - valid/ready holding register for received words
// Owns the parallel output, its parity flag, the valid flag and overrun detection.
module sipo_rx_out_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_parity_err,
    input  logic                  Data_Ready_In,
    output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
    output logic                  Data_Valid_Out,
    output logic                  Parity_Error_Out,
    output logic                  Overrun_Error_Out
);

    // A new word may land when the slot is empty or is being drained on this edge.
    logic slot_free;
    assign slot_free = !Data_Valid_Out || Data_Ready_In;

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            Parallel_Data_Out <= '0;
            Data_Valid_Out    <= 1'b0;
            Parity_Error_Out  <= 1'b0;
            Overrun_Error_Out <= 1'b0;
        end else begin
            Overrun_Error_Out <= 1'b0;
            if (load && slot_free) begin
                Parallel_Data_Out <= load_data;
                Parity_Error_Out  <= load_parity_err;
                Data_Valid_Out    <= 1'b1;
            end else if (load) begin
                Overrun_Error_Out <= 1'b1;
            end else if (Data_Ready_In) begin
                Data_Valid_Out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_in_parallel_out_sipo_rx.sv
// rtl/serial_in_parallel_out_sipo_rx.sv - LSB-first serial receiver with framed valid/ready output
// Optional feature macro: SIPO_RX_PARITY_CHECK_EN (even-parity bit after the data bits).
module serial_in_parallel_out_sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Serial_Data_In,
    input  logic                  Serial_Valid_In,
    input  logic                  Frame_Start_In,
    output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
    output logic                  Data_Valid_Out,
    input  logic                  Data_Ready_In,
    output logic                  Busy_Out,
    output logic                  Overrun_Error_Out,
    output logic                  Parity_Error_Out
);

    state_t                state, state_next;
    logic [CNT_WIDTH-1:0]  count, count_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next, shifted;
    logic [DATA_WIDTH-1:0] word_data;
    logic                  word_load, word_perr;

    assign shifted  = {Serial_Data_In, shift_reg[DATA_WIDTH-1:1]};
    assign Busy_Out = (state != IDLE);

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            shift_reg <= shift_next;
        end
    end

    // A start strobe in any state re-frames: the incoming bit becomes bit0.
    always_comb begin
        state_next = state;
        count_next = count;
        shift_next = shift_reg;
        word_load  = 1'b0;
        word_data  = '0;
        word_perr  = 1'b0;
        if (Serial_Valid_In) begin
            if (Frame_Start_In) begin
                shift_next = shifted;
                count_next = CNT_WIDTH'(1);
                state_next = SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        shift_next = shifted;
                        if (count == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                            count_next = '0;
`ifdef SIPO_RX_PARITY_CHECK_EN
                            state_next = PARITY;
`else
                            state_next = IDLE;
                            word_load  = 1'b1;
                            word_data  = shifted;
`endif
                        end else begin
                            count_next = count + CNT_WIDTH'(1);
                        end
                    end
`ifdef SIPO_RX_PARITY_CHECK_EN
                    PARITY: begin
                        // The parity bit is checked but never shifted into the word.
                        state_next = IDLE;
                        word_load  = 1'b1;
                        word_data  = shift_reg;
                        word_perr  = ^{shift_reg, Serial_Data_In};
                    end
`endif
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    sipo_rx_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .Clk_In            (Clk_In),
        .Reset_In          (Reset_In),
        .load              (word_load),
        .load_data         (word_data),
        .load_parity_err   (word_perr),
        .Data_Ready_In     (Data_Ready_In),
        .Parallel_Data_Out (Parallel_Data_Out),
        .Data_Valid_Out    (Data_Valid_Out),
        .Parity_Error_Out  (Parity_Error_Out),
        .Overrun_Error_Out (Overrun_Error_Out)
    );

endmodule

// File: tb/tb_serial_in_parallel_out_sipo_rx.sv
// tb/tb_serial_in_parallel_out_sipo_rx.sv - directed self-checking bench for serial_in_parallel_out_sipo_rx
// Honours SIPO_RX_PARITY_CHECK_EN by appending an even-parity bit to every frame.
module tb_serial_in_parallel_out_sipo_rx;

`ifdef SIPO_RX_PARITY_CHECK_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       Clk_In = 1'b0;
    logic       Reset_In = 1'b1;
    logic       Serial_Data_In = 1'b0;
    logic       Serial_Valid_In = 1'b0;
    logic       Frame_Start_In = 1'b0;
    logic [7:0] Parallel_Data_Out;
    logic       Data_Valid_Out;
    logic       Data_Ready_In = 1'b1;
    logic       Busy_Out;
    logic       Overrun_Error_Out;
    logic       Parity_Error_Out;

    int checks = 0;
    int failures = 0;

    serial_in_parallel_out_sipo_rx #(.DATA_WIDTH(8)) dut (
        .Clk_In            (Clk_In),
        .Reset_In          (Reset_In),
        .Serial_Data_In    (Serial_Data_In),
        .Serial_Valid_In   (Serial_Valid_In),
        .Frame_Start_In    (Frame_Start_In),
        .Parallel_Data_Out (Parallel_Data_Out),
        .Data_Valid_Out    (Data_Valid_Out),
        .Data_Ready_In     (Data_Ready_In),
        .Busy_Out          (Busy_Out),
        .Overrun_Error_Out (Overrun_Error_Out),
        .Parity_Error_Out  (Parity_Error_Out)
    );

    always #5 Clk_In = ~Clk_In;

    task automatic tick();
        @(posedge Clk_In);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] w, input int i);
        return (i < 8) ? w[i] : ^w;
    endfunction

    // Drives one full frame (start on bit0), leaving `gap` idle cycles after each bit except the last.
    task automatic send_frame(input logic [7:0] w, input int gap);
        for (int i = 0; i < NB; i++) begin
            Serial_Valid_In = 1'b1;
            Serial_Data_In  = frame_bit(w, i);
            Frame_Start_In  = (i == 0);
            tick();
            Serial_Valid_In = 1'b0;
            Frame_Start_In  = 1'b0;
            if (i < NB - 1) repeat (gap) tick();
        end
    endtask

    initial begin
        // Reset state
        Reset_In = 1'b1;
        tick(); tick();
        Reset_In = 1'b0;
        chk("rst_data", 32'(Parallel_Data_Out), 32'h00);
        chk("rst_valid", 32'(Data_Valid_Out), 32'h0);
        chk("rst_busy", 32'(Busy_Out), 32'h0);
        chk("rst_ovr", 32'(Overrun_Error_Out), 32'h0);
        chk("rst_par", 32'(Parity_Error_Out), 32'h0);

        // Test 1: back-to-back bits of 8'hA5, Ready=1
        Data_Ready_In = 1'b1;
        for (int i = 0; i < NB; i++) begin
            Serial_Valid_In = 1'b1;
            Serial_Data_In  = frame_bit(8'hA5, i);
            Frame_Start_In  = (i == 0);
            tick();
            if (i < NB - 1) begin
                chk("t1_busy_mid", 32'(Busy_Out), 32'h1);
                chk("t1_valid_mid", 32'(Data_Valid_Out), 32'h0);
            end
        end
        Serial_Valid_In = 1'b0;
        Frame_Start_In  = 1'b0;
        chk("t1_valid", 32'(Data_Valid_Out), 32'h1);
        chk("t1_data", 32'(Parallel_Data_Out), 32'hA5);
        chk("t1_busy_end", 32'(Busy_Out), 32'h0);
        chk("t1_par", 32'(Parity_Error_Out), 32'h0);
        tick();
        chk("t1_valid_drop", 32'(Data_Valid_Out), 32'h0);

        // Test 2: 8'h3C with a bit every third cycle
        for (int i = 0; i < NB; i++) begin
            Serial_Valid_In = 1'b1;
            Serial_Data_In  = frame_bit(8'h3C, i);
            Frame_Start_In  = (i == 0);
            tick();
            Serial_Valid_In = 1'b0;
            Frame_Start_In  = 1'b0;
            if (i < NB - 1) begin
                chk("t2_busy", 32'(Busy_Out), 32'h1);
                chk("t2_valid_mid", 32'(Data_Valid_Out), 32'h0);
                repeat (2) begin
                    tick();
                    chk("t2_busy_gap", 32'(Busy_Out), 32'h1);
                end
            end
        end
        chk("t2_valid", 32'(Data_Valid_Out), 32'h1);
        chk("t2_data", 32'(Parallel_Data_Out), 32'h3C);
        chk("t2_busy_end", 32'(Busy_Out), 32'h0);
        tick();
        chk("t2_single", 32'(Data_Valid_Out), 32'h0);

        // Test 3: overrun with Ready=0
        Data_Ready_In = 1'b0;
        send_frame(8'h11, 0);
        chk("t3_valid1", 32'(Data_Valid_Out), 32'h1);
        chk("t3_data1", 32'(Parallel_Data_Out), 32'h11);
        chk("t3_ovr_none", 32'(Overrun_Error_Out), 32'h0);
        tick();
        send_frame(8'h22, 0);
        chk("t3_ovr", 32'(Overrun_Error_Out), 32'h1);
        chk("t3_hold", 32'(Parallel_Data_Out), 32'h11);
        chk("t3_valid_hold", 32'(Data_Valid_Out), 32'h1);
        tick();
        chk("t3_ovr_pulse", 32'(Overrun_Error_Out), 32'h0);
        chk("t3_hold2", 32'(Parallel_Data_Out), 32'h11);
        Data_Ready_In = 1'b1;
        tick();
        chk("t3_accept", 32'(Data_Valid_Out), 32'h0);

        // Test 4: 5-bit partial frame, then a restart with a full 8'h5A
        for (int i = 0; i < 5; i++) begin
            Serial_Valid_In = 1'b1;
            Serial_Data_In  = 1'b1;
            Frame_Start_In  = (i == 0);
            tick();
        end
        chk("t4_partial_valid", 32'(Data_Valid_Out), 32'h0);
        chk("t4_partial_busy", 32'(Busy_Out), 32'h1);
        send_frame(8'h5A, 0);
        chk("t4_valid", 32'(Data_Valid_Out), 32'h1);
        chk("t4_data", 32'(Parallel_Data_Out), 32'h5A);
        chk("t4_ovr", 32'(Overrun_Error_Out), 32'h0);
        tick();
        chk("t4_single", 32'(Data_Valid_Out), 32'h0);

        // Test 5: reset mid-frame, then unframed bits are ignored
        for (int i = 0; i < 4; i++) begin
            Serial_Valid_In = 1'b1;
            Serial_Data_In  = 1'b1;
            Frame_Start_In  = (i == 0);
            tick();
        end
        Serial_Valid_In = 1'b0;
        Frame_Start_In  = 1'b0;
        Reset_In = 1'b1;
        tick();
        Reset_In = 1'b0;
        chk("t5_data", 32'(Parallel_Data_Out), 32'h00);
        chk("t5_valid", 32'(Data_Valid_Out), 32'h0);
        chk("t5_busy", 32'(Busy_Out), 32'h0);
        for (int i = 0; i < NB; i++) begin
            Serial_Valid_In = 1'b1;
            Serial_Data_In  = 1'b1;
            tick();
            chk("t5_ign_busy", 32'(Busy_Out), 32'h0);
            chk("t5_ign_valid", 32'(Data_Valid_Out), 32'h0);
        end
        Serial_Valid_In = 1'b0;
        tick();
        chk("t5_ign_data", 32'(Parallel_Data_Out), 32'h00);
        chk("t5_ign_ovr", 32'(Overrun_Error_Out), 32'h0);

`ifdef SIPO_RX_PARITY_CHECK_EN
        // Test 6: good and bad parity on 8'hA5
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 9; i++) begin
                Serial_Valid_In = 1'b1;
                Serial_Data_In  = (i < 8) ? frame_bit(8'hA5, i) : p[0];
                Frame_Start_In  = (i == 0);
                tick();
                if (i == 7) chk("t6_busy_parity", 32'(Busy_Out), 32'h1);
            end
            Serial_Valid_In = 1'b0;
            Frame_Start_In  = 1'b0;
            chk("t6_valid", 32'(Data_Valid_Out), 32'h1);
            chk("t6_data", 32'(Parallel_Data_Out), 32'hA5);
            chk("t6_perr", 32'(Parity_Error_Out), 32'(p));
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
